// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: takes one word access per request, drives a
// multi-cycle data memory port, stalls upstream until done, then returns a 1-cycle response.
module mem_access_ctrl #(
    parameter int unsigned MEM_LAT = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [15:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        stall_o,
    output logic        resp_valid_o,
    output logic [15:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        misalign_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic [15:0] mem_rdata_i,
    input  logic        mem_data_valid_i
);

    localparam int unsigned MaxCnt = (MEM_LAT > TIMEOUT) ? MEM_LAT : TIMEOUT;
    localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q;
    logic              we_q;
    logic [CntW-1:0]   cnt_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [15:0]       mem_addr_q;
    logic [15:0]       mem_wdata_q;
    logic              misalign_q;
    logic              resp_valid_q;
    logic [15:0]       resp_rdata_q;
    logic              resp_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            misalign_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            // Strobes default low; each is raised only on entry to the state that owns it.
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            misalign_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        we_q        <= req_we_i;
                        mem_addr_q  <= {req_addr_i[15:1], 1'b0};
                        mem_wdata_q <= req_wdata_i;
                        misalign_q  <= req_addr_i[0];
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= req_we_i;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= we_q ? CntW'(MEM_LAT - 1) : CntW'(TIMEOUT - 1);
                    state_q <= StWait;
                end
                StWait: begin
                    if (we_q) begin
                        if (cnt_q == '0) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= StDone;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end else if (mem_data_valid_i) begin
                        // Data arriving on the last timeout cycle still counts as success.
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= mem_rdata_i;
                        state_q      <= StDone;
                    end else if (cnt_q == '0) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o  = ~rst_i & (state_q == StIdle);
    assign stall_o      = ~rst_i & (((state_q == StIdle) & req_valid_i) |
                                    (state_q == StIssue) | (state_q == StWait));
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign misalign_o   = misalign_q;
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a cycle-scheduled transaction model checked every cycle,
// directed scenarios with literal timing expectations, then randomized traffic.
module tb_mem_access_ctrl;

    localparam int unsigned MEM_LAT = 4;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [15:0] mem_rdata = '0;
    logic        mem_data_valid = 1'b0;
    logic        req_ready_o, stall_o, resp_valid_o, resp_err_o, misalign_o;
    logic        mem_en_o, mem_we_o;
    logic [15:0] resp_rdata_o, mem_addr_o, mem_wdata_o;

    mem_access_ctrl #(.MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_we_i        (req_we),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .req_ready_o     (req_ready_o),
        .stall_o         (stall_o),
        .resp_valid_o    (resp_valid_o),
        .resp_rdata_o    (resp_rdata_o),
        .resp_err_o      (resp_err_o),
        .misalign_o      (misalign_o),
        .mem_en_o        (mem_en_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rdata_i     (mem_rdata),
        .mem_data_valid_i(mem_data_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Transaction model: an accepted request at cycle t0 owns the port until its response
    // cycle; mem_en lands at t0+1, a store responds at t0+2+MEM_LAT, a load one cycle
    // after the first data-valid in [t0+2, t0+1+TIMEOUT], or errors after that window.
    bit          m_busy = 1'b0;
    int          m_t0 = 0;
    int          m_resp = -1;
    bit          m_we = 1'b0;
    bit          m_mis = 1'b0;
    bit          m_err = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_rdata = '0;

    int          n_en = 0, n_resp = 0, n_mis = 0;
    int          obs_en = -1, obs_resp = -1, obs_mis = -1, obs_acc = -1;
    logic        obs_we = 1'b0, obs_err = 1'b0;
    logic [15:0] obs_addr = '0, obs_wdata = '0, obs_rdata = '0;

    always @(negedge clk) begin
        logic e_ready, e_stall, e_first, e_resp;
        e_ready = !rst && !m_busy;
        e_resp  = m_busy && (cyc == m_resp);
        e_stall = !rst && ((!m_busy && req_valid) || (m_busy && cyc != m_resp));
        e_first = m_busy && (cyc == m_t0 + 1);
        chk1("req_ready", req_ready_o, e_ready);
        chk1("stall", stall_o, e_stall);
        chk1("mem_en", mem_en_o, e_first);
        chk1("mem_we", mem_we_o, e_first && m_we);
        chk1("misalign", misalign_o, e_first && m_mis);
        chk1("resp_valid", resp_valid_o, e_resp);
        chk16("mem_addr", mem_addr_o, m_addr);
        chk16("mem_wdata", mem_wdata_o, m_wdata);
        if (e_resp) begin
            chk16("resp_rdata", resp_rdata_o, m_rdata);
            chk1("resp_err", resp_err_o, m_err);
        end

        if (req_valid && req_ready_o) obs_acc = cyc;
        if (mem_en_o) begin
            n_en++; obs_en = cyc; obs_we = mem_we_o; obs_addr = mem_addr_o;
            obs_wdata = mem_wdata_o;
        end
        if (resp_valid_o) begin
            n_resp++; obs_resp = cyc; obs_rdata = resp_rdata_o; obs_err = resp_err_o;
        end
        if (misalign_o) begin
            n_mis++; obs_mis = cyc;
        end

        if (rst) begin
            m_busy = 1'b0; m_addr = '0; m_wdata = '0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1'b1; m_t0 = cyc; m_we = req_we; m_mis = req_addr[0];
                m_addr = {req_addr[15:1], 1'b0}; m_wdata = req_wdata;
                m_resp = req_we ? cyc + 2 + int'(MEM_LAT) : -1;
                m_err = 1'b0; m_rdata = '0;
            end
        end else if (cyc == m_resp) begin
            m_busy = 1'b0;
        end else if (!m_we && m_resp < 0 && cyc >= m_t0 + 2) begin
            if (mem_data_valid) begin
                m_resp = cyc + 1; m_rdata = mem_rdata;
            end else if (cyc == m_t0 + 1 + int'(TIMEOUT)) begin
                m_resp = cyc + 1; m_err = 1'b1;
            end
        end
    end

    // Memory responder: answers a load rsp_dly cycles after its mem_en, or random noise.
    int          rsp_dly = -1;
    int          cd = 0;
    logic [15:0] rsp_word = '0;
    bit          noise = 1'b0;

    always @(posedge clk) begin
        #1;
        mem_data_valid = 1'b0;
        if (noise) begin
            mem_data_valid = ($urandom_range(3) == 0);
            mem_rdata = 16'($urandom);
        end else if (mem_en_o && !mem_we_o && rsp_dly > 0) begin
            cd = rsp_dly;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mem_data_valid = 1'b1;
                mem_rdata = rsp_word;
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                         output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (req_ready_o) begin
                got = 1'b1;
                acc = cyc;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!got) chk1("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_resp(input int base);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            #1;
            if (n_resp > base) got = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!got) chk1("resp_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, base, be, bm, r1;
        step(3);
        rst = 1'b0;
        step(2);

        // Load with data 3 cycles after mem_en.
        rsp_dly = 3; rsp_word = 16'hBEEF; base = n_resp;
        issue(1'b0, 16'h0010, 16'h0000, a);
        wait_resp(base);
        chki("t1_en_lat", obs_en - a, 1);
        chk1("t1_en_we", obs_we, 1'b0);
        chk16("t1_en_addr", obs_addr, 16'h0010);
        chki("t1_resp_lat", obs_resp - a, 5);
        chk16("t1_rdata", obs_rdata, 16'hBEEF);
        chk1("t1_err", obs_err, 1'b0);
        step(2);

        // Store timing.
        base = n_resp;
        issue(1'b1, 16'h0020, 16'h1234, a);
        wait_resp(base);
        chki("t2_en_lat", obs_en - a, 1);
        chk1("t2_en_we", obs_we, 1'b1);
        chk16("t2_en_addr", obs_addr, 16'h0020);
        chk16("t2_en_wdata", obs_wdata, 16'h1234);
        chki("t2_resp_lat", obs_resp - a, 6);
        chk16("t2_rdata", obs_rdata, 16'h0000);
        step(1);

        // Misaligned load.
        rsp_dly = 2; rsp_word = 16'h0A0B; base = n_resp; bm = n_mis;
        issue(1'b0, 16'h0033, 16'h0000, a);
        wait_resp(base);
        chki("t3_mis_count", n_mis - bm, 1);
        chki("t3_mis_lat", obs_mis - a, 1);
        chk16("t3_addr", obs_addr, 16'h0032);
        step(1);

        // Load timeout, then data on the final WAIT cycle.
        rsp_dly = -1; base = n_resp;
        issue(1'b0, 16'h0100, 16'h0000, a);
        wait_resp(base);
        chki("t4_to_lat", obs_resp - a, 18);
        chk1("t4_to_err", obs_err, 1'b1);
        chk16("t4_to_rdata", obs_rdata, 16'h0000);
        step(1);
        rsp_dly = 16; rsp_word = 16'hCAFE; base = n_resp;
        issue(1'b0, 16'h0102, 16'h0000, a);
        wait_resp(base);
        chki("t4_late_lat", obs_resp - a, 18);
        chk1("t4_late_err", obs_err, 1'b0);
        chk16("t4_late_rdata", obs_rdata, 16'hCAFE);
        step(1);

        // Reset during WAIT abandons the access; late data is ignored.
        rsp_dly = 8; rsp_word = 16'hDEAD; base = n_resp;
        issue(1'b0, 16'h0040, 16'h0000, a);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(12);
        chki("t5_no_resp", n_resp - base, 0);
        chk16("t5_addr_cleared", mem_addr_o, 16'h0000);
        rsp_dly = 2; rsp_word = 16'h5A5A; base = n_resp;
        issue(1'b0, 16'h0044, 16'h0000, a);
        wait_resp(base);
        chk16("t5_next_rdata", obs_rdata, 16'h5A5A);
        chk1("t5_next_err", obs_err, 1'b0);
        step(1);

        // req_valid held for two back-to-back loads.
        rsp_dly = 2; rsp_word = 16'h7777; base = n_resp; be = n_en; r1 = -1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0050;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            #1;
            if (n_resp == base + 1 && r1 < 0) r1 = obs_resp;
            if (n_resp >= base + 2) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        step(3);
        chki("t6_en_count", n_en - be, 2);
        chki("t6_resp_count", n_resp - base, 2);
        chki("t6_second_accept", obs_acc - r1, 1);

        // Randomized traffic with noisy memory and occasional resets.
        noise = 1'b1;
        for (int i = 0; i < 500; i++) begin
            rst       = ($urandom_range(79) == 0);
            req_valid = $urandom_range(1) == 1;
            req_we    = $urandom_range(1) == 1;
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            step(1);
        end
        rst = 1'b0; req_valid = 1'b0;
        step(25);
        noise = 1'b0;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
